// File: rtl/pin_match_engine.sv
// pin_match_engine
// ----------------
// PIN verification engine for the door-lock keypad path. It accepts a captured
// PIN over a ready/valid handshake, takes one cycle to compare it against the
// master PIN and the enabled user slots, and then presents a one-cycle verdict
// strobe. It also counts consecutive failures and enforces a timed lockout.
// If no master PIN is programmed yet, only the factory code is recognised. That
// code authorises the first master update.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   req_valid/_ready/_pin   PIN request handshake (digit1 in the MSBs)
//   master_pin, master_set  programmed master PIN and its "programmed" flag
//   user_pins, user_en      user PIN slots (slot 0 in the LSBs) and enables
//   res_valid      one-cycle result strobe
//   res_master/res_user/res_update/res_fail  one-hot verdict while res_valid
//   res_idx        matching user slot (0 unless res_user)
//   fail_count     consecutive failures, saturating at MAX_FAILS
//   locked         lockout active
module pin_match_engine #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int NUM_PINS    = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter logic [DIGITS*DIGIT_W-1:0] FACTORY_CODE = 16'h1234,
  localparam int PIN_W = DIGITS * DIGIT_W,
  localparam int IDX_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1,
  localparam int FC_W  = $clog2(MAX_FAILS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [PIN_W-1:0]          req_pin,
  input  logic [PIN_W-1:0]          master_pin,
  input  logic                      master_set,
  input  logic [NUM_PINS*PIN_W-1:0] user_pins,
  input  logic [NUM_PINS-1:0]       user_en,
  output logic                      res_valid,
  output logic                      res_master,
  output logic                      res_user,
  output logic                      res_update,
  output logic                      res_fail,
  output logic [IDX_W-1:0]          res_idx,
  output logic [FC_W-1:0]           fail_count,
  output logic                      locked
);

  // The lock counter only needs to hold LOCK_CYCLES-1, because the counter
  // value 0 is itself the last locked cycle.
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [FC_W-1:0]   FC_MAX    = FC_W'(MAX_FAILS);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESULT, S_LOCKED} state_t;
  typedef enum logic [1:0] {V_FAIL, V_MASTER, V_USER, V_UPDATE} verdict_t;

  state_t            state_q,   state_d;
  verdict_t          verdict_q, verdict_d;
  logic [PIN_W-1:0]  pin_q,     pin_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [FC_W-1:0]   fail_q,    fail_d;
  logic [LOCK_W-1:0] lock_q,    lock_d;

  // Combinational verdict for the captured PIN. Only the CHECK state registers
  // it, so the configuration inputs matter only in that cycle.
  verdict_t         verdict_c;
  logic [IDX_W-1:0] idx_c;

  always_comb begin
    // NOTE: every always_comb output gets a default first. If a path left one
    // unassigned, synthesis would infer a latch.
    verdict_c = V_FAIL;
    idx_c     = '0;
    if (!master_set) begin
      if (pin_q == FACTORY_CODE) verdict_c = V_UPDATE;
    end else if (pin_q == master_pin) begin
      verdict_c = V_MASTER;
    end else begin
      // The loop scans from the highest slot down, so the last hit it sees is
      // the lowest-index enabled slot.
      for (int i = NUM_PINS - 1; i >= 0; i--) begin
        if (user_en[i] && (user_pins[i*PIN_W +: PIN_W] == pin_q)) begin
          verdict_c = V_USER;
          idx_c     = IDX_W'(i);
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    pin_d     = pin_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    lock_d    = lock_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          pin_d   = req_pin;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        verdict_d = verdict_c;
        idx_d     = idx_c;
        state_d   = S_RESULT;
      end
      S_RESULT: begin
        if (verdict_q != V_FAIL) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else if (int'(fail_q) + 1 < MAX_FAILS) begin
          fail_d  = fail_q + FC_W'(1);
          state_d = S_IDLE;
        end else begin
          fail_d  = FC_MAX;
          lock_d  = LOCK_LOAD;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (lock_q == '0) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q - LOCK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      verdict_q <= V_FAIL;
      pin_q     <= '0;
      idx_q     <= '0;
      fail_q    <= '0;
      lock_q    <= '0;
    end else begin
      state_q   <= state_d;
      verdict_q <= verdict_d;
      pin_q     <= pin_d;
      idx_q     <= idx_d;
      fail_q    <= fail_d;
      lock_q    <= lock_d;
    end
  end

  // The outputs decode registered state, so the strobe is glitch-free and
  // holds exactly the RESULT cycle.
  assign req_ready  = (state_q == S_IDLE);
  assign res_valid  = (state_q == S_RESULT);
  assign res_master = res_valid && (verdict_q == V_MASTER);
  assign res_user   = res_valid && (verdict_q == V_USER);
  assign res_update = res_valid && (verdict_q == V_UPDATE);
  assign res_fail   = res_valid && (verdict_q == V_FAIL);
  assign res_idx    = res_user ? idx_q : '0;
  assign fail_count = fail_q;
  assign locked     = (state_q == S_LOCKED);

endmodule

// File: tb/tb_pin_match_engine.sv
// Testbench for pin_match_engine. A table of request vectors, each with its
// expected verdict and fail count, is applied in a loop. Expected verdicts are
// queued when a request is driven and checked when res_valid strobes.
// Hand-written sequences cover latency, lockout, reset aborts and
// configuration timing.
module tb_pin_match_engine;

  localparam int LOCK = 8;

  localparam logic [3:0] F_M  = 4'b1000;  // {master, user, update, fail}
  localparam logic [3:0] F_U  = 4'b0100;
  localparam logic [3:0] F_UP = 4'b0010;
  localparam logic [3:0] F_F  = 4'b0001;

  localparam logic [63:0] UP_STD  = {16'h2222, 16'h5555, 16'h5555, 16'h1111};
  localparam logic [63:0] UP_ZERO = 64'h0;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [15:0] req_pin, master_pin;
  logic        master_set;
  logic [63:0] user_pins;
  logic [3:0]  user_en;
  logic        res_valid, res_master, res_user, res_update, res_fail;
  logic [1:0]  res_idx;
  logic [1:0]  fail_count;
  logic        locked;

  pin_match_engine #(.LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pin(req_pin),
    .master_pin(master_pin), .master_set(master_set),
    .user_pins(user_pins), .user_en(user_en),
    .res_valid(res_valid), .res_master(res_master), .res_user(res_user),
    .res_update(res_update), .res_fail(res_fail), .res_idx(res_idx),
    .fail_count(fail_count), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] flags;
    logic [1:0] idx;
  } exp_t;

  typedef struct {
    logic        mset;
    logic [15:0] mpin;
    logic [63:0] upins;
    logic [3:0]  uen;
    logic [15:0] pin;
    logic [3:0]  flags;
    logic [1:0]  idx;
    logic [1:0]  fc;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard consumer: every result strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_flags", {res_master, res_user, res_update, res_fail}, mon_e.flags);
        check("res_idx", res_idx, mon_e.idx);
      end
    end
  end

  // This task returns one time unit after the handshake edge, while the DUT is
  // in CHECK.
  task automatic send(input logic [15:0] pin, input exp_t e, input bit push);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
    req_pin   = pin;
    req_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // This task waits for the queued result, then steps past the edge that
  // leaves RESULT, so fail_count shows its updated value on return.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_async_locked", locked, 0);
    check("rst_async_fail_count", fail_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_res_valid", res_valid, 0);
    check("post_rst_locked", locked, 0);
    check("post_rst_fail_count", fail_count, 0);
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt, bad, n;
    bit   seen;
    exp_t e;

    vecs[0]  = '{1'b0, 16'h9876, UP_STD,  4'b0110, 16'h1234, F_UP, 2'd0, 2'd0};
    vecs[1]  = '{1'b1, 16'h9876, UP_STD,  4'b0110, 16'h5555, F_U,  2'd1, 2'd0};
    vecs[2]  = '{1'b1, 16'h9876, UP_STD,  4'b0100, 16'h5555, F_U,  2'd2, 2'd0};
    vecs[3]  = '{1'b1, 16'h9876, UP_STD,  4'b0110, 16'h9876, F_M,  2'd0, 2'd0};
    vecs[4]  = '{1'b0, 16'h9876, UP_STD,  4'b0110, 16'h9876, F_F,  2'd0, 2'd1};
    vecs[5]  = '{1'b1, 16'h9876, UP_ZERO, 4'b0000, 16'h0000, F_F,  2'd0, 2'd2};
    vecs[6]  = '{1'b1, 16'h9876, UP_ZERO, 4'b0000, 16'h9876, F_M,  2'd0, 2'd0};
    vecs[7]  = '{1'b1, 16'h9876, UP_STD,  4'b1111, 16'h1234, F_F,  2'd0, 2'd1};
    vecs[8]  = '{1'b1, 16'h9876, UP_STD,  4'b1111, 16'h2222, F_U,  2'd3, 2'd0};
    vecs[9]  = '{1'b1, 16'h9876, UP_ZERO, 4'b0001, 16'h0000, F_U,  2'd0, 2'd0};
    vecs[10] = '{1'b0, 16'h9876, UP_STD,  4'b1111, 16'h5555, F_F,  2'd0, 2'd1};
    vecs[11] = '{1'b1, 16'h9876, UP_STD,  4'b0010, 16'h1111, F_F,  2'd0, 2'd2};
    vecs[12] = '{1'b1, 16'h9876, UP_STD,  4'b0010, 16'h5555, F_U,  2'd1, 2'd0};

    rst = 1'b1; req_valid = 1'b0; req_pin = '0;
    master_pin = 16'h9876; master_set = 1'b0; user_pins = UP_STD; user_en = 4'b0110;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_res_valid", res_valid, 0);
    check("reset_locked", locked, 0);
    check("reset_fail_count", fail_count, 0);
    check("reset_res_idx", res_idx, 0);

    // Cycle-exact latency: factory code with no master programmed.
    req_pin = 16'h1234; req_valid = 1'b1;
    exp_q.push_back('{flags: F_UP, idx: 2'd0});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("lat_n1_ready", req_ready, 0);
    check("lat_n1_res_valid", res_valid, 0);
    @(negedge clk);
    check("lat_n2_ready", req_ready, 0);
    check("lat_n2_res_valid", res_valid, 1);
    @(negedge clk);
    check("lat_n3_ready", req_ready, 1);
    check("lat_n3_res_valid", res_valid, 0);
    check("lat_n3_fail_count", fail_count, 0);

    // Table-driven verdicts.
    foreach (vecs[i]) begin
      master_set = vecs[i].mset;
      master_pin = vecs[i].mpin;
      user_pins  = vecs[i].upins;
      user_en    = vecs[i].uen;
      send(vecs[i].pin, '{flags: vecs[i].flags, idx: vecs[i].idx}, 1'b1);
      drain();
      check($sformatf("vec%0d_fail_count", i), fail_count, vecs[i].fc);
    end

    // Lockout: three failures, then exactly LOCK locked cycles. A master PIN
    // held valid throughout must be ignored.
    master_set = 1'b1; master_pin = 16'h9876; user_pins = UP_STD; user_en = 4'b0110;
    e = '{flags: F_F, idx: 2'd0};
    send(16'h0001, e, 1'b1); drain(); check("lock_fc1", fail_count, 1);
    send(16'h0001, e, 1'b1); drain(); check("lock_fc2", fail_count, 2);
    send(16'h0001, e, 1'b1);
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("lock_third_strobe", res_valid, 1);
    req_pin = 16'h9876; req_valid = 1'b1;
    cnt = 0; bad = 0; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (locked) begin
        cnt++;
        seen = 1'b1;
        if (req_ready) bad++;
        if (cnt == 1) check("locked_fail_count", fail_count, 3);
      end else if (seen) begin
        break;
      end
    end
    check("lock_cycles", cnt, LOCK);
    check("lock_ready_low", bad, 0);
    check("unlock_fail_count", fail_count, 0);
    check("unlock_ready", req_ready, 1);
    exp_q.push_back('{flags: F_M, idx: 2'd0});
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
    check("after_unlock_fc", fail_count, 0);

    // Config change during CHECK counts; a change during RESULT does not.
    user_pins = {48'h0, 16'h4444}; user_en = 4'b0001;
    send(16'h4444, '{flags: F_F, idx: 2'd0}, 1'b1);
    user_pins[15:0] = 16'h7777;
    drain();
    check("cfg_check_fc", fail_count, 1);
    user_pins[15:0] = 16'h4444;
    send(16'h4444, '{flags: F_U, idx: 2'd0}, 1'b1);
    @(posedge clk);
    #1 user_pins[15:0] = 16'h7777;
    drain();
    check("cfg_result_fc", fail_count, 0);

    // Reset during CHECK aborts without a strobe.
    user_pins = UP_ZERO; user_en = 4'b0000;
    send(16'h0001, '{flags: F_F, idx: 2'd0}, 1'b1);
    drain();
    check("pre_rst_fc", fail_count, 1);
    send(16'h9876, '{flags: F_M, idx: 2'd0}, 1'b0);
    do_reset();

    // Reset in the middle of a lockout.
    e = '{flags: F_F, idx: 2'd0};
    send(16'h0001, e, 1'b1); drain();
    send(16'h0001, e, 1'b1); drain();
    send(16'h0001, e, 1'b1); drain();
    check("pre_rst_locked", locked, 1);
    check("pre_rst_locked_fc", fail_count, 3);
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pin_match_engine.md
Name: pin_match_engine

Overview:
- Parametrised PIN verification engine for the door-lock keypad path.
- Accepts a captured PIN through a ready/valid handshake and compares it against a master PIN and NUM_PINS user slots.
- Before a master PIN is programmed, it recognises only the factory code, which authorises the first master update.
- Adds consecutive-failure counting and a timed lockout. Sits between the keypad capture logic and the setup/door-control FSMs.

Parameters:
DIGITS, 4, number of digits per PIN (>=1)
DIGIT_W, 4, bits per digit
NUM_PINS, 4, number of user PIN slots (>=1)
MAX_FAILS, 3, consecutive failures that trigger lockout (>=1)
LOCK_CYCLES, 1000, lockout duration in clk cycles (>=1)
FACTORY_CODE, 16'h1234, factory master code (DIGITS*DIGIT_W bits, digit1 in MSBs)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  PIN request valid
req_ready  out  1  engine can accept a request
req_pin  in  DIGITS*DIGIT_W  entered PIN, digit1 in MSBs
master_pin  in  DIGITS*DIGIT_W  programmed master PIN
master_set  in  1  master PIN has been programmed
user_pins  in  NUM_PINS*DIGITS*DIGIT_W  user PINs, slot 0 in LSBs
user_en  in  NUM_PINS  slot enable
res_valid  out  1  one-cycle result strobe
res_master  out  1  master PIN matched
res_user  out  1  enabled user PIN matched
res_update  out  1  factory code matched while master_set=0
res_fail  out  1  no match
res_idx  out  max(1,$clog2(NUM_PINS))  matching user slot
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures
locked  out  1  lockout active

Behaviour:
- Reset, asynchronous and immediate:
  - Outputs: state=IDLE, res_* = 0, res_idx=0, fail_count=0, locked=0, lock counter=0, captured PIN=0.
  - req_ready=1 after release.
  - A reset in any state aborts the operation; no result strobe is produced.
- States: IDLE, CHECK, RESULT, LOCKED.
- req_ready = (state==IDLE). Handshake completes on any edge with req_valid && req_ready.
  - At that edge: req_pin is registered, state goes to CHECK.
  - req_valid outside IDLE is ignored; it is neither queued nor counted.
- CHECK (one cycle):
  - The registered PIN is compared against master_pin, master_set, user_pins and user_en as sampled in this cycle.
  - Verdict is registered; state goes to RESULT.
- Verdict priority:
  - master_set=0: PIN==FACTORY_CODE gives update; anything else gives fail. User slots and master_pin are not consulted.
  - master_set=1: PIN==master_pin gives master. Otherwise the lowest-index slot i with user_en[i]=1 and PIN==slot i gives user with res_idx=i. Otherwise fail.
  - Disabled slots never match, including an all-zero PIN against an all-zero disabled slot.
- RESULT (one cycle):
  - res_valid=1 and exactly one of res_master/res_user/res_update/res_fail is 1.
  - res_idx is meaningful only with res_user; otherwise 0.
  - All res_* are 0 outside RESULT.
- Latency: handshake edge N gives res_valid high in cycle N+2; req_ready is high again in cycle N+3. Maximum throughput is one request per 3 cycles.
- Fail counting, updated on the edge leaving RESULT:
  - Success (master/user/update): fail_count becomes 0, next state IDLE.
  - Fail with fail_count+1 < MAX_FAILS: fail_count increments, next state IDLE.
  - Fail with fail_count+1 == MAX_FAILS: fail_count=MAX_FAILS, lock counter=LOCK_CYCLES-1, next state LOCKED.
  - fail_count never exceeds MAX_FAILS and never wraps.
- LOCKED:
  - locked=1, req_ready=0. The lock counter decrements each cycle.
  - On the edge where the counter is 0: next state IDLE, fail_count=0, locked=0.
  - Lockout therefore lasts exactly LOCK_CYCLES cycles. A correct master PIN cannot bypass it.
- The lock counter is sized for LOCK_CYCLES-1; there is no wrap-around.
- Config inputs changing in IDLE or RESULT have no effect on the current verdict.

Test Plan:
- Reset, then master_set=0, PIN 1234 at edge N -> res_valid & res_update in cycle N+2, fail_count=0, req_ready low for cycles N+1..N+2.
- master_set=1, master_pin=9876, user_en=4'b0110, slots 1 and 2 both =5555, PIN 5555 -> res_user, res_idx=1. Repeat with slot 1 disabled -> res_idx=2. PIN 9876 -> res_master.
- master_set=1: PIN 0000 against all-zero slots with user_en=0 -> res_fail, fail_count=1. Then correct PIN -> success, fail_count=0.
- LOCK_CYCLES=8, three wrong PINs -> third result is res_fail; locked=1 for exactly 8 cycles, req_ready=0. req_valid held high with the correct master PIN is ignored. After the 8 cycles: fail_count=0, the request is accepted, res_master.
- Assert rst during CHECK and again mid-LOCKED -> no res_valid, locked=0, fail_count=0, req_ready=1 on the first cycle after release.
- Change user_pins during CHECK vs. during RESULT -> the verdict follows the CHECK-cycle value only.
